// File: rtl/tiny_synth_pkg.sv
// Shared definitions for the synth voice: envelope state encoding and noise LFSR constants.
package tiny_synth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int              LFSR_BITS  = 23;
  localparam logic [22:0]     LFSR_SEED  = 23'h7FFFF8;
  localparam int              LFSR_TAP_A = 22;
  localparam int              LFSR_TAP_B = 17;

endpackage

// File: rtl/adsr_envelope_param.sv
// ADSR envelope with run-time rates; level is ENV_BITS+8 bits with 8 fraction bits.
module adsr_envelope_param
  import tiny_synth_pkg::*;
#(
  parameter int ENV_BITS  = 8,
  parameter int RATE_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  gate,
  input  logic [RATE_BITS-1:0]  attack_inc,
  input  logic [RATE_BITS-1:0]  decay_inc,
  input  logic [RATE_BITS-1:0]  release_inc,
  input  logic [ENV_BITS-1:0]   sustain_level,
  output logic [ENV_BITS+7:0]   level,
  output env_state_t            state,
  output logic                  is_idle
);

  localparam int LEVEL_BITS = ENV_BITS + 8;
  // One spare bit above the wider of level/rate so sums and bounds never wrap.
  localparam int W = ((RATE_BITS > LEVEL_BITS) ? RATE_BITS : LEVEL_BITS) + 1;

  logic [LEVEL_BITS-1:0] level_reg;
  env_state_t            state_reg;

  logic [LEVEL_BITS-1:0] sustain_full;
  logic [W-1:0]          level_ext, sustain_ext, full_ext;
  logic [W-1:0]          attack_sum, decay_diff, release_diff;
  logic                  attack_done, decay_done, release_done;

  assign sustain_full = {sustain_level, 8'h00};
  assign level_ext    = W'(level_reg);
  assign sustain_ext  = W'(sustain_full);
  assign full_ext     = W'({LEVEL_BITS{1'b1}});

  assign attack_sum   = level_ext + W'(attack_inc);
  assign decay_diff   = level_ext - W'(decay_inc);
  assign release_diff = level_ext - W'(release_inc);
  assign attack_done  = attack_sum >= full_ext;
  assign decay_done   = level_ext <= (sustain_ext + W'(decay_inc));
  assign release_done = level_ext <= W'(release_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      level_reg <= '0;
    end else if (sample_tick) begin
      // Gate edges take priority; a zero rate holds both state and level.
      case (state_reg)
        IDLE: begin
          if (gate) state_reg <= ATTACK;
        end
        ATTACK: begin
          if (!gate) begin
            state_reg <= RELEASE;
          end else if (attack_inc != '0) begin
            if (attack_done) begin
              level_reg <= '1;
              state_reg <= DECAY;
            end else begin
              level_reg <= attack_sum[LEVEL_BITS-1:0];
            end
          end
        end
        DECAY: begin
          if (!gate) begin
            state_reg <= RELEASE;
          end else if (decay_inc != '0) begin
            if (decay_done) begin
              level_reg <= sustain_full;
              state_reg <= SUSTAIN;
            end else begin
              level_reg <= decay_diff[LEVEL_BITS-1:0];
            end
          end
        end
        SUSTAIN: begin
          if (!gate) state_reg <= RELEASE;
          else       level_reg <= sustain_full;
        end
        RELEASE: begin
          if (gate) begin
            state_reg <= ATTACK;
          end else if (release_inc != '0) begin
            if (release_done) begin
              level_reg <= '0;
              state_reg <= IDLE;
            end else begin
              level_reg <= release_diff[LEVEL_BITS-1:0];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign level   = level_reg;
  assign state   = state_reg;
  assign is_idle = (state_reg == IDLE);

endmodule

// File: rtl/voice_param.sv
// Programmable synth voice: phase-accumulator tone, ADSR envelope and amplitude scaler.
// Define VOICE_PARAM_GLIDE_EN to enable portamento (cur_freq slews toward tone_freq).
module voice_param
  import tiny_synth_pkg::*;
#(
  parameter int OUTPUT_BITS      = 12,
  parameter int FREQ_BITS        = 16,
  parameter int PULSEWIDTH_BITS  = 12,
  parameter int ACCUMULATOR_BITS = 24,
  parameter int ENV_BITS         = 8,
  parameter int RATE_BITS        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic [FREQ_BITS-1:0]        tone_freq,
  input  logic [PULSEWIDTH_BITS-1:0]  pulse_width,
  input  logic [3:0]                  waveform,
  input  logic                        gate,
  input  logic [RATE_BITS-1:0]        attack_inc,
  input  logic [RATE_BITS-1:0]        decay_inc,
  input  logic [RATE_BITS-1:0]        release_inc,
  input  logic [ENV_BITS-1:0]         sustain_level,
  input  logic [FREQ_BITS-1:0]        glide_inc,
  input  logic                        en_ringmod,
  input  logic                        ringmod_source,
  input  logic                        en_sync,
  input  logic                        sync_source,
  output logic signed [OUTPUT_BITS-1:0] dout,
  output logic [ENV_BITS-1:0]         env_amplitude,
  output logic                        accumulator_msb,
  output logic                        accumulator_overflow,
  output logic                        is_idle
);

  localparam int MSB        = ACCUMULATOR_BITS - 1;
  localparam int LEVEL_BITS = ENV_BITS + 8;
  localparam int PROD_BITS  = OUTPUT_BITS + ENV_BITS + 1;

  logic [ACCUMULATOR_BITS-1:0] acc_reg, acc_next;
  logic [ACCUMULATOR_BITS:0]   acc_sum;
  logic                        overflow_reg;
  logic [LFSR_BITS-1:0]        lfsr_reg;
  logic [FREQ_BITS-1:0]        cur_freq;
  logic                        sync_now, noise_step;

  logic [OUTPUT_BITS-1:0] saw, tri_t, tri_w, pulse, noise, raw, wave_next;
  logic                   fold;
  logic signed [OUTPUT_BITS-1:0] wave_reg, dout_reg;
  logic [ENV_BITS-1:0]           env_amp_reg;
  logic signed [PROD_BITS-1:0]   product, scaled;

  logic [LEVEL_BITS-1:0] env_level;
  env_state_t            env_state;
  logic                  unused_env;

`ifdef VOICE_PARAM_GLIDE_EN
  logic [FREQ_BITS-1:0] cur_freq_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_freq_reg <= '0;
    end else if (sample_tick) begin
      if (glide_inc == '0 || cur_freq_reg == tone_freq)
        cur_freq_reg <= tone_freq;
      else if (cur_freq_reg < tone_freq)
        cur_freq_reg <= (tone_freq - cur_freq_reg <= glide_inc) ? tone_freq : cur_freq_reg + glide_inc;
      else
        cur_freq_reg <= (cur_freq_reg - tone_freq <= glide_inc) ? tone_freq : cur_freq_reg - glide_inc;
    end
  end

  assign cur_freq = cur_freq_reg;
`else
  logic unused_glide;
  assign unused_glide = ^glide_inc;
  assign cur_freq     = tone_freq;
`endif

  assign sync_now   = en_sync & sync_source;
  assign acc_sum    = {1'b0, acc_reg} + (ACCUMULATOR_BITS + 1)'(cur_freq);
  assign acc_next   = sync_now ? '0 : acc_sum[MSB:0];
  // Noise clocks off a rising edge of a fixed accumulator bit, so its rate tracks pitch.
  assign noise_step = acc_next[ACCUMULATOR_BITS-5] & ~acc_reg[ACCUMULATOR_BITS-5];

  assign saw   = acc_reg[MSB -: OUTPUT_BITS];
  assign tri_t = acc_reg[MSB-1 -: OUTPUT_BITS];
  assign fold  = acc_reg[MSB] ^ (en_ringmod & ringmod_source);
  assign tri_w = fold ? ~tri_t : tri_t;
  assign pulse = (acc_reg[MSB -: PULSEWIDTH_BITS] >= pulse_width) ? '1 : '0;
  assign noise = lfsr_reg[LFSR_BITS-1 -: OUTPUT_BITS];

  genvar gi;
  generate
    for (gi = 0; gi < OUTPUT_BITS; gi++) begin : g_mix
      assign raw[gi] = (noise[gi] | ~waveform[0]) & (pulse[gi] | ~waveform[1]) &
                       (tri_w[gi] | ~waveform[2]) & (saw[gi]   | ~waveform[3]);
    end
  endgenerate

  // Offset-binary to two's complement by flipping the sign bit.
  assign wave_next = (waveform == 4'd0) ? '0 : {~raw[OUTPUT_BITS-1], raw[OUTPUT_BITS-2:0]};

  assign product = $signed({{(ENV_BITS+1){wave_reg[OUTPUT_BITS-1]}}, wave_reg}) *
                   $signed({{OUTPUT_BITS{1'b0}}, 1'b0, env_amp_reg});
  assign scaled  = product >>> ENV_BITS;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg      <= '0;
      overflow_reg <= 1'b0;
      lfsr_reg     <= LFSR_SEED;
      wave_reg     <= '0;
      env_amp_reg  <= '0;
      dout_reg     <= '0;
    end else if (sample_tick) begin
      acc_reg      <= acc_next;
      overflow_reg <= ~sync_now & acc_sum[ACCUMULATOR_BITS];
      if (noise_step)
        lfsr_reg <= {lfsr_reg[LFSR_BITS-2:0], lfsr_reg[LFSR_TAP_A] ^ lfsr_reg[LFSR_TAP_B]};
      wave_reg     <= wave_next;
      env_amp_reg  <= env_level[LEVEL_BITS-1 -: ENV_BITS];
      dout_reg     <= scaled[OUTPUT_BITS-1:0];
    end
  end

  adsr_envelope_param #(
    .ENV_BITS  (ENV_BITS),
    .RATE_BITS (RATE_BITS)
  ) u_env (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .gate          (gate),
    .attack_inc    (attack_inc),
    .decay_inc     (decay_inc),
    .release_inc   (release_inc),
    .sustain_level (sustain_level),
    .level         (env_level),
    .state         (env_state),
    .is_idle       (is_idle)
  );

  assign unused_env = ^{env_level[LEVEL_BITS-ENV_BITS-1:0], env_state};

  assign dout                 = dout_reg;
  assign env_amplitude        = env_amp_reg;
  assign accumulator_msb      = acc_reg[MSB];
  assign accumulator_overflow = overflow_reg;

endmodule

// File: tb/tb_voice_param.sv
// Randomised bench for voice_param against an arithmetic reference model of the voice.
module tb_voice_param;

  localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;
  localparam int ACC_MOD = 1 << 24;

  logic        clk = 1'b0;
  logic        rst, sample_tick, gate;
  logic [15:0] tone_freq, attack_inc, decay_inc, release_inc, glide_inc;
  logic [11:0] pulse_width;
  logic [3:0]  waveform;
  logic [7:0]  sustain_level;
  logic        en_ringmod, ringmod_source, en_sync, sync_source;
  logic signed [11:0] dout;
  logic [7:0]  env_amplitude;
  logic        accumulator_msb, accumulator_overflow, is_idle;

  always #5 clk = ~clk;

  voice_param dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .tone_freq(tone_freq),
    .pulse_width(pulse_width), .waveform(waveform), .gate(gate),
    .attack_inc(attack_inc), .decay_inc(decay_inc), .release_inc(release_inc),
    .sustain_level(sustain_level), .glide_inc(glide_inc),
    .en_ringmod(en_ringmod), .ringmod_source(ringmod_source),
    .en_sync(en_sync), .sync_source(sync_source),
    .dout(dout), .env_amplitude(env_amplitude), .accumulator_msb(accumulator_msb),
    .accumulator_overflow(accumulator_overflow), .is_idle(is_idle)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int m_acc, m_ovf, m_cur, m_state, m_level, m_wave, m_env, m_dout;
  bit [22:0] m_lfsr;

  task automatic model_reset();
    m_acc = 0; m_ovf = 0; m_lfsr = 23'h7FFFF8;
    m_state = S_IDLE; m_level = 0;
    m_wave = 0; m_env = 0; m_dout = 0;
`ifdef VOICE_PARAM_GLIDE_EN
    m_cur = 0;
`else
    m_cur = int'(tone_freq);
`endif
  endtask

  task automatic model_tick();
    int raw, t, f, nwave, nenv, ndout, sum, old_acc, sus, inc;
    old_acc = m_acc;
    if (waveform == 4'd0) nwave = 0;
    else begin
      raw = 'hFFF;
      if (waveform[3]) raw &= (m_acc >> 12) & 'hFFF;
      if (waveform[2]) begin
        t = (m_acc >> 11) & 'hFFF;
        f = ((m_acc >> 23) & 1) ^ int'(en_ringmod & ringmod_source);
        if (f != 0) t = 'hFFF - t;
        raw &= t;
      end
      if (waveform[1]) raw &= (((m_acc >> 12) & 'hFFF) >= int'(pulse_width)) ? 'hFFF : 0;
      if (waveform[0]) raw &= int'(m_lfsr >> 11) & 'hFFF;
      nwave = raw - 2048;
    end
    nenv  = m_level / 256;
    ndout = (m_wave * m_env) >>> 8;

`ifndef VOICE_PARAM_GLIDE_EN
    m_cur = int'(tone_freq);
`endif
    if (en_sync && sync_source) begin
      m_acc = 0; m_ovf = 0;
    end else begin
      sum = m_acc + m_cur;
      m_ovf = (sum >= ACC_MOD) ? 1 : 0;
      m_acc = sum % ACC_MOD;
    end
    if (((m_acc >> 19) & 1) == 1 && ((old_acc >> 19) & 1) == 0)
      m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};

`ifdef VOICE_PARAM_GLIDE_EN
    inc = int'(glide_inc);
    if (inc == 0) m_cur = int'(tone_freq);
    else if (m_cur < int'(tone_freq)) m_cur = (m_cur + inc > int'(tone_freq)) ? int'(tone_freq) : m_cur + inc;
    else m_cur = (m_cur - inc < int'(tone_freq)) ? int'(tone_freq) : m_cur - inc;
`endif

    sus = int'(sustain_level) * 256;
    if (m_state == S_IDLE) begin
      if (gate) m_state = S_ATT;
    end else if (m_state == S_REL) begin
      if (gate) m_state = S_ATT;
      else if (release_inc != 0) begin
        m_level -= int'(release_inc);
        if (m_level <= 0) begin m_level = 0; m_state = S_IDLE; end
      end
    end else if (!gate) begin
      m_state = S_REL;
    end else if (m_state == S_ATT) begin
      if (attack_inc != 0) begin
        m_level += int'(attack_inc);
        if (m_level >= 65535) begin m_level = 65535; m_state = S_DEC; end
      end
    end else if (m_state == S_DEC) begin
      if (decay_inc != 0) begin
        m_level -= int'(decay_inc);
        if (m_level <= sus) begin m_level = sus; m_state = S_SUS; end
      end
    end else begin
      m_level = sus;
    end

    m_wave = nwave; m_env = nenv; m_dout = ndout;
  endtask

  task automatic step(input bit t, input string tag);
    sample_tick = t;
    @(posedge clk);
    if (rst) model_reset();
    else if (t) model_tick();
    @(negedge clk);
    check({tag, ".dout"}, dout, m_dout);
    check({tag, ".env"}, env_amplitude, m_env);
    check({tag, ".idle"}, is_idle, (m_state == S_IDLE) ? 1 : 0);
    check({tag, ".ovf"}, accumulator_overflow, m_ovf);
    check({tag, ".msb"}, accumulator_msb, (m_acc >> 23) & 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, "rst");
    rst = 1'b0;
  endtask

  int ovf_cnt;

  initial begin
    rst = 1'b1; sample_tick = 1'b0; gate = 1'b0;
    tone_freq = 16'h1000; pulse_width = 12'h800; waveform = 4'b1000;
    attack_inc = 16'hFFFF; decay_inc = 16'h0001; release_inc = 16'h0100;
    sustain_level = 8'hFF; glide_inc = 16'h0000;
    en_ringmod = 1'b0; ringmod_source = 1'b0; en_sync = 1'b0; sync_source = 1'b0;
    model_reset();

    // Reset: three cycles of rst, tick every fourth cycle
    for (int i = 0; i < 3; i++) step(i % 4 == 0, "reset");
    rst = 1'b0;
    check("reset_dout", dout, 0);
    check("reset_idle", is_idle, 1);
    check("reset_ovf", accumulator_overflow, 0);
    check("reset_env", env_amplitude, 0);

    // Saw with overflow counting
    gate = 1'b1;
    ovf_cnt = 0;
    for (int i = 0; i < 8200; i++) begin
      step(1'b1, "saw");
      if (accumulator_overflow) ovf_cnt++;
    end
    check("saw_ovf_count", ovf_cnt, 2);

    // ADSR sequence
    gate = 1'b0; do_reset();
    waveform = 4'b1000; tone_freq = 16'h0123;
    attack_inc = 16'h0100; decay_inc = 16'h0080; sustain_level = 8'h80; release_inc = 16'h0100;
    gate = 1'b1;
    for (int i = 0; i < 258; i++) step(1'b1, "attack");
    check("attack_peak", env_amplitude, 8'hFF);
    for (int i = 0; i < 342; i++) step(1'b1, "decay");
    check("sustain_env", env_amplitude, 8'h80);

    // Release to 0x4000 then retrigger
    gate = 1'b0;
    for (int i = 0; i < 65; i++) step(1'b1, "release");
    gate = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, "retrig");
    check("retrig_env", env_amplitude, 8'h41);
    for (int i = 0; i < 600; i++) step(1'b1, "reattack");
    check("resustain_env", env_amplitude, 8'h80);
    gate = 1'b0;
    for (int i = 0; i < 128; i++) step(1'b1, "release2");
    check("release_not_idle", is_idle, 0);
    step(1'b1, "release2");
    check("release_idle", is_idle, 1);

    // Sync on a would-be carry tick
    do_reset();
    tone_freq = 16'h8000; waveform = 4'b0100; gate = 1'b1;
    for (int i = 0; i < 511; i++) step(1'b1, "presync");
    check("presync_msb", accumulator_msb, 1);
    en_sync = 1'b1; sync_source = 1'b1;
    step(1'b1, "sync");
    check("sync_msb", accumulator_msb, 0);
    check("sync_ovf", accumulator_overflow, 0);
    sync_source = 1'b0;
    step(1'b1, "postsync");

    // Randomised run including idle cycles and mid-note resets
    for (int i = 0; i < 4000; i++) begin
      waveform    = 4'($urandom);
      pulse_width = 12'($urandom);
      if ($urandom_range(0, 31) == 0) tone_freq = 16'($urandom);
      if ($urandom_range(0, 63) == 0) gate = ~gate;
      if ($urandom_range(0, 127) == 0) begin
        attack_inc  = 16'($urandom_range(1, 4096));
        decay_inc   = 16'($urandom_range(1, 4096));
        release_inc = 16'($urandom_range(1, 4096));
        sustain_level = 8'($urandom);
        glide_inc   = 16'($urandom_range(0, 512));
      end
      en_ringmod     = 1'($urandom);
      ringmod_source = 1'($urandom);
      en_sync        = 1'($urandom);
      sync_source    = ($urandom_range(0, 15) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      step($urandom_range(0, 7) != 0, "rand");
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
